image_row_loader: RTL and testbench
===================================

Name: image_row_loader

Overview:
- Write-side front end for the coprocessor image container.
- Accepts a frame as a stream of 32-bit words over a valid/ready handshake.
- Packs each group of 96 words into one 3072-bit image row.
- Issues one single-cycle write per row on the container's write port (we/waddr/wdata), interleaving rows across the three banks so that any three consecutive rows can be read in parallel.

Parameters:
- WORD_BITS, 32, width of the input stream word.
- ROW_BITS, 3072, width of one image row; must be a multiple of WORD_BITS.
- WORDS_PER_ROW, ROW_BITS/WORD_BITS (96), words packed per row.
- ROWS_PER_BANK, 96, rows held by each bank.
- NUM_ROWS, 288, rows per frame; must be ≤ 3*ROWS_PER_BANK.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  begin a frame; honoured only in IDLE.
- abort  input  1  synchronous abandon of the current frame.
- in_valid  input  1  stream word valid.
- in_data  input  WORD_BITS  stream word.
- in_ready  output  1  loader can accept a word.
- we  output  1  container write enable; one-cycle pulse per row.
- waddr  output  9  container write address: bits [8:7] = bank, bits [6:0] = local row.
- wdata  output  ROW_BITS  packed row.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after the last row is written.
- row_idx  output  9  number of rows written in the current frame.

Behaviour:
- Reset: clk and rst only; reset is asynchronous, active-high. All registers clear: state=IDLE; in_ready, we, busy, done = 0; waddr, wdata, row_idx = 0. Reset mid-frame discards any partial row and issues no write.
- States:
  - IDLE: start=1 → FILL. Clears word_cnt, bank, local_row and row_idx.
  - FILL: in_ready=1. Each cycle with in_valid & in_ready, in_data is written to wdata[word_cnt*WORD_BITS +: WORD_BITS] (word 0 at the LSBs) and word_cnt increments. Acceptance of word WORDS_PER_ROW-1 → WRITE next cycle. in_valid=0 holds state with no change.
  - WRITE: exactly one cycle; we=1; in_ready=0. waddr = {bank, local_row}. wdata is stable and holds the full row.
    - If row_idx+1 == NUM_ROWS → DONE.
    - Otherwise → FILL with word_cnt=0.
    - The row pointer advances on exit from WRITE:
      - bank increments 0→1→2→0.
      - local_row increments only when bank wraps 2→0.
      - row_idx increments.
  - DONE: done=1 for one cycle, in_ready=0 → IDLE. busy drops in IDLE.
- Address mapping: image row r → bank = r mod 3, local_row = r div 3. This is maintained incrementally; no divider. Bank encodings are 2'b00, 2'b01, 2'b10; 2'b11 is never driven.
- Latency: we asserts the cycle after the 96th word handshake. The maximum stream rate is 96 words per 97 cycles.
- abort (synchronous) → IDLE next cycle from any state. A write in progress is not issued (abort outranks WRITE). done does not pulse. Partial-row data is discarded.
- start while not IDLE: ignored. start and abort together in IDLE: abort wins; the loader stays in IDLE.
- wdata retains its contents between rows; bits not yet overwritten in FILL are don't-care until WRITE.
- WRITE/DONE are back-pressured: in_ready=0 while in these states, so no word is lost or duplicated.

Decomposition:
- Shared coproc package holds:
  - loader state enum (IDLE, FILL, WRITE, DONE);
  - BANK_ADDR_W=2 and LOCAL_ROW_W=7;
  - bank encodings BANK0/1/2;
  - ROW_BITS and WORD_BITS constants shared with the container.
- One natural sub-module: image_row_addr_gen. It is the bank/local_row/row_idx counter, with inputs clear and advance, and outputs waddr, row_idx and last_row.

Test Plan:
- Reset with in_valid=1 held → in_ready=0, we=0, busy=0, waddr=0, done=0. After reset release with start=0, the loader stays in IDLE.
- start, then 96 back-to-back words with value k (0..95) → exactly one we pulse in the cycle after word 95. waddr=9'h000. wdata[31:0]=0, wdata[3071:3040]=95.
- Full 288-row frame, with word j of row r = {r[15:0], j[15:0]}:
  - 288 we pulses.
  - Rows 0,1,2 → waddr 0x000, 0x080, 0x100. Row 3 → 0x001. Row 287 → 0x15F.
  - done pulses one cycle after the last we; busy=0 afterward.
- Random in_valid gaps (≈30% idle) on a 3-row frame → the same wdata/waddr as the gap-free run. in_ready=0 exactly on WRITE cycles.
- abort after word 50 of row 4 → no we for row 4, IDLE next cycle. A new start then writes row 0 at waddr 0x000.
- Async rst pulse mid-WRITE (between clock edges) → we drops immediately, no done. start then restarts at row 0.

Source files
------------

// File: rtl/image_row_loader_pkg.sv
// ---------------------------------------------------------------------------
// image_row_loader_pkg
// Constants and types shared between the image row loader and the
// coprocessor image container: stream/row geometry, bank addressing and
// the loader state encoding.
// ---------------------------------------------------------------------------
package image_row_loader_pkg;

  localparam int WORD_BITS     = 32;
  localparam int ROW_BITS      = 3072;
  localparam int WORDS_PER_ROW = ROW_BITS / WORD_BITS;
  localparam int ROWS_PER_BANK = 96;
  localparam int NUM_ROWS      = 288;

  localparam int BANK_ADDR_W = 2;
  localparam int LOCAL_ROW_W = 7;
  localparam int ROW_ADDR_W  = BANK_ADDR_W + LOCAL_ROW_W;
  localparam int ROW_IDX_W   = 9;
  localparam int WORD_CNT_W  = 7;

  localparam logic [BANK_ADDR_W-1:0] BANK0 = 2'b00;
  localparam logic [BANK_ADDR_W-1:0] BANK1 = 2'b01;
  localparam logic [BANK_ADDR_W-1:0] BANK2 = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FILL  = 2'b01,
    WRITE = 2'b10,
    DONE  = 2'b11
  } loader_state_e;

  // Bank rotation 0 -> 1 -> 2 -> 0; the unused code 2'b11 recovers to BANK0.
  function automatic logic [BANK_ADDR_W-1:0] next_bank(input logic [BANK_ADDR_W-1:0] bank);
    logic [BANK_ADDR_W-1:0] nb;
    case (bank)
      BANK0:   nb = BANK1;
      BANK1:   nb = BANK2;
      BANK2:   nb = BANK0;
      default: nb = BANK0;
    endcase
    return nb;
  endfunction

endpackage

// File: rtl/image_row_loader_addr_gen.sv
// ---------------------------------------------------------------------------
// image_row_addr_gen
// Incremental row pointer for the banked image container. Image row r lives
// at bank = r mod 3, local_row = r div 3; both are tracked by counters so no
// divider is needed.
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : zero the pointer (start of frame)
//   advance   : step to the next image row
//   waddr     : {bank, local_row} of the current row
//   row_idx   : rows completed in the current frame
//   last_row  : current row is the final row of the frame
// ---------------------------------------------------------------------------
module image_row_addr_gen
  import image_row_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  advance,
  output logic [ROW_ADDR_W-1:0] waddr,
  output logic [ROW_IDX_W-1:0]  row_idx,
  output logic                  last_row
);

  logic [BANK_ADDR_W-1:0] bank_r;
  logic [LOCAL_ROW_W-1:0] local_row_r;
  logic [ROW_IDX_W-1:0]   row_idx_r;

  // Row pointer: bank rotates every row, local_row steps when the bank wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_r      <= BANK0;
      local_row_r <= 7'd0;
      row_idx_r   <= 9'd0;
    end else if (clear) begin
      bank_r      <= BANK0;
      local_row_r <= 7'd0;
      row_idx_r   <= 9'd0;
    end else if (advance) begin
      bank_r    <= next_bank(bank_r);
      row_idx_r <= row_idx_r + 9'd1;
      if (bank_r == BANK2) begin
        local_row_r <= local_row_r + 7'd1;
      end
    end
  end

  assign waddr    = {bank_r, local_row_r};
  assign row_idx  = row_idx_r;
  assign last_row = (row_idx_r == 9'(NUM_ROWS - 1));

endmodule

// File: rtl/image_row_loader.sv
// ---------------------------------------------------------------------------
// image_row_loader
// Write-side front end of the coprocessor image container. Packs 96 stream
// words into one 3072-bit row and writes each row into the container with a
// single-cycle pulse, interleaving rows across three banks.
//   clk, rst  : clock, asynchronous active-high reset
//   start     : begin a frame (IDLE only)
//   abort     : synchronous abandon of the current frame
//   in_valid, in_data, in_ready : 32-bit input stream handshake
//   we, waddr, wdata : container write port
//   busy      : loader not IDLE
//   done      : one-cycle pulse after the last row of a frame
//   row_idx   : rows written in the current frame
// ---------------------------------------------------------------------------
module image_row_loader
  import image_row_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  in_valid,
  input  logic [WORD_BITS-1:0]  in_data,
  output logic                  in_ready,
  output logic                  we,
  output logic [ROW_ADDR_W-1:0] waddr,
  output logic [ROW_BITS-1:0]   wdata,
  output logic                  busy,
  output logic                  done,
  output logic [ROW_IDX_W-1:0]  row_idx
);

  loader_state_e           state_r;
  loader_state_e           state_nxt_s;
  logic [WORD_CNT_W-1:0]   word_cnt_r;
  logic [ROW_BITS-1:0]     wdata_r;
  logic                    in_ready_r;
  logic                    we_r;
  logic                    busy_r;
  logic                    done_r;
  logic                    clear_s;
  logic                    advance_s;
  logic                    accept_s;
  logic                    last_word_s;
  logic                    last_row_s;

  assign accept_s    = in_valid & in_ready_r;
  assign last_word_s = (word_cnt_r == 7'(WORDS_PER_ROW - 1));

  image_row_addr_gen u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear_s),
    .advance  (advance_s),
    .waddr    (waddr),
    .row_idx  (row_idx),
    .last_row (last_row_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; abort outranks every other transition.
  always_comb begin
    state_nxt_s = state_r;
    clear_s     = 1'b0;
    advance_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (abort) begin
          state_nxt_s = IDLE;
        end else if (start) begin
          state_nxt_s = FILL;
          clear_s     = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FILL: begin
        if (abort) begin
          state_nxt_s = IDLE;
        end else if (accept_s && last_word_s) begin
          state_nxt_s = WRITE;
        end else begin
          state_nxt_s = FILL;
        end
      end
      WRITE: begin
        if (abort) begin
          state_nxt_s = IDLE;
        end else begin
          advance_s = 1'b1;
          if (last_row_s) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = FILL;
          end
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Status outputs registered from the next state so they align with state_r.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_r <= 1'b0;
      we_r       <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      in_ready_r <= (state_nxt_s == FILL);
      we_r       <= (state_nxt_s == WRITE);
      busy_r     <= (state_nxt_s != IDLE);
      done_r     <= (state_nxt_s == DONE);
    end
  end

  // Word counter: counts accepted words in FILL, held at zero elsewhere.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt_r <= 7'd0;
    end else if (state_r != FILL) begin
      word_cnt_r <= 7'd0;
    end else if (accept_s) begin
      word_cnt_r <= word_cnt_r + 7'd1;
    end
  end

  // Row assembly: word 0 lands in the least significant bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdata_r <= {ROW_BITS{1'b0}};
    end else if (accept_s) begin
      wdata_r[word_cnt_r*WORD_BITS +: WORD_BITS] <= in_data;
    end
  end

  // An abort arriving in the WRITE cycle itself still suppresses the write.
  assign we       = we_r & ~abort;
  assign in_ready = in_ready_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign wdata    = wdata_r;

endmodule

// File: tb/tb_image_row_loader.sv
// ---------------------------------------------------------------------------
// tb_image_row_loader
// Self-checking bench for image_row_loader. A reference model derives each
// expected row (address from r mod 3 / r div 3, data from a word pattern)
// and compares it with every write captured on the container port.
// ---------------------------------------------------------------------------
module tb_image_row_loader;
  import image_row_loader_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic          in_valid;
  logic [31:0]   in_data;
  logic          in_ready;
  logic          we;
  logic [8:0]    waddr;
  logic [3071:0] wdata;
  logic          busy;
  logic          done;
  logic [8:0]    row_idx;

  int n_checks = 0;
  int n_pass   = 0;

  // Monitor state (written only by the monitor process)
  int            cyc = 0;
  int            hs_last_cyc = 0;
  int            ready_err = 0;
  int            notready_busy = 0;
  logic [8:0]    we_addr_q[$];
  logic [3071:0] we_data_q[$];
  int            we_cyc_q[$];
  int            done_cyc_q[$];

  image_row_loader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .row_idx  (row_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Sample everything mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (in_valid === 1'b1 && in_ready === 1'b1) hs_last_cyc = cyc;
    if (busy === 1'b1 && in_ready === 1'b0) notready_busy = notready_busy + 1;
    if (we === 1'b1) begin
      we_addr_q.push_back(waddr);
      we_data_q.push_back(wdata);
      we_cyc_q.push_back(cyc);
      if (in_ready !== 1'b0) ready_err = ready_err + 1;
    end
    if (done === 1'b1) done_cyc_q.push_back(cyc);
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] exp_word(input int mode, input int r, input int j);
    logic [31:0] rr;
    logic [31:0] jj;
    rr = 32'(r);
    jj = 32'(j);
    if (mode == 0) return jj;
    return {rr[15:0], jj[15:0]};
  endfunction

  function automatic logic [8:0] exp_addr(input int r);
    return 9'((r % 3) * 128 + (r / 3));
  endfunction

  function automatic int row_mismatch(input logic [3071:0] d, input int mode, input int r);
    int n = 0;
    for (int j = 0; j < 96; j++)
      if (d[j*32 +: 32] !== exp_word(mode, r, j)) n++;
    return n;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
  endtask

  // Present one word with random idle gaps; returns just after its handshake edge.
  task automatic send_word(input logic [31:0] d, input int gap_pct);
    int   guard = 0;
    logic acc;
    in_data = d;
    forever begin
      in_valid = ($urandom_range(99) >= gap_pct);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      guard++;
      if (guard > 1000) begin
        check("handshake_timeout", 64'(guard), 64'd0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_row(input int mode, input int r, input int nwords, input int gap_pct);
    for (int j = 0; j < nwords; j++) send_word(exp_word(mode, r, j), gap_pct);
  endtask

  task automatic check_rows(input string tag, input int base, input int nrows, input int mode);
    for (int k = 0; k < nrows; k++) begin
      if (base + k >= we_addr_q.size()) begin
        check({tag, "_row_missing"}, 64'(we_addr_q.size()), 64'(base + nrows));
        return;
      end
      check({tag, "_waddr"}, 64'(we_addr_q[base+k]), 64'(exp_addr(k)));
      check({tag, "_wdata_bad_words"}, 64'(row_mismatch(we_data_q[base+k], mode, k)), 64'd0);
    end
  endtask

  initial begin
    int            base;
    int            dbase;
    int            nr_base;
    int            re_base;
    logic [3071:0] d;

    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b1; in_data = 32'h0;

    // 1) reset state with in_valid held high
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_we",       64'(we),       64'd0);
    check("rst_busy",     64'(busy),     64'd0);
    check("rst_waddr",    64'(waddr),    64'd0);
    check("rst_done",     64'(done),     64'd0);
    check("rst_row_idx",  64'(row_idx),  64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick(5);
    check("idle_busy",     64'(busy),              64'd0);
    check("idle_in_ready", 64'(in_ready),          64'd0);
    check("idle_no_we",    64'(we_addr_q.size()),  64'd0);
    in_valid = 1'b0;

    // 2) single row, word k = k, back-to-back
    base = we_addr_q.size();
    pulse_start();
    check("start_busy", 64'(busy), 64'd1);
    send_row(0, 0, 96, 0);
    tick(3);
    check("row0_we_count", 64'(we_addr_q.size() - base), 64'd1);
    if (we_addr_q.size() > base) begin
      d = we_data_q[base];
      check("row0_waddr",   64'(we_addr_q[base]), 64'h000);
      check("row0_word0",   64'(d[31:0]),         64'd0);
      check("row0_word95",  64'(d[3071:3040]),    64'd95);
      check("row0_latency", 64'(we_cyc_q[base]),  64'(hs_last_cyc + 1));
      check("row0_bad_words", 64'(row_mismatch(d, 0, 0)), 64'd0);
    end
    check("row0_row_idx", 64'(row_idx), 64'd1);
    pulse_abort();
    check("row0_abort_busy", 64'(busy), 64'd0);

    // 3) 3-row frame with ~30% idle gaps
    base    = we_addr_q.size();
    nr_base = notready_busy;
    re_base = ready_err;
    pulse_start();
    for (int r = 0; r < 3; r++) send_row(1, r, 96, 30);
    tick(2);
    pulse_abort();
    check("gap_we_count", 64'(we_addr_q.size() - base), 64'd3);
    check_rows("gap", base, 3, 1);
    check("gap_ready_on_write", 64'(ready_err - re_base),       64'd0);
    check("gap_notready_cycles", 64'(notready_busy - nr_base),  64'd3);

    // 4) full 288-row frame
    base  = we_addr_q.size();
    dbase = done_cyc_q.size();
    pulse_start();
    for (int r = 0; r < 288; r++) send_row(1, r, 96, 0);
    tick(5);
    check("frame_we_count", 64'(we_addr_q.size() - base), 64'd288);
    check_rows("frame", base, 288, 1);
    if (we_addr_q.size() >= base + 288) begin
      check("frame_waddr_r1",   64'(we_addr_q[base+1]),   64'h080);
      check("frame_waddr_r2",   64'(we_addr_q[base+2]),   64'h100);
      check("frame_waddr_r3",   64'(we_addr_q[base+3]),   64'h001);
      check("frame_waddr_r287", 64'(we_addr_q[base+287]), 64'h15F);
    end
    check("frame_done_count", 64'(done_cyc_q.size() - dbase), 64'd1);
    if (done_cyc_q.size() > dbase && we_cyc_q.size() > 0)
      check("frame_done_timing", 64'(done_cyc_q[dbase]), 64'(we_cyc_q[we_cyc_q.size()-1] + 1));
    check("frame_busy_after", 64'(busy),    64'd0);
    check("frame_row_idx",    64'(row_idx), 64'd288);

    // 5) abort after word 50 of row 4
    base  = we_addr_q.size();
    dbase = done_cyc_q.size();
    pulse_start();
    for (int r = 0; r < 4; r++) send_row(1, r, 96, 0);
    send_row(1, 4, 51, 0);
    pulse_abort();
    check("abort_busy",     64'(busy),     64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd0);
    tick(100);
    check("abort_we_count",   64'(we_addr_q.size() - base),    64'd4);
    check("abort_done_count", 64'(done_cyc_q.size() - dbase),  64'd0);
    base = we_addr_q.size();
    pulse_start();
    send_row(1, 0, 96, 0);
    tick(3);
    check("restart_we_count", 64'(we_addr_q.size() - base), 64'd1);
    check_rows("restart", base, 1, 1);
    pulse_abort();

    // 6) asynchronous reset during WRITE
    base  = we_addr_q.size();
    dbase = done_cyc_q.size();
    pulse_start();
    send_row(1, 0, 96, 0);
    check("arst_we_before", 64'(we), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("arst_we_now",   64'(we),   64'd0);
    check("arst_busy_now", 64'(busy), 64'd0);
    check("arst_done_now", 64'(done), 64'd0);
    #2 rst = 1'b0;
    tick(5);
    check("arst_no_write", 64'(we_addr_q.size() - base),   64'd0);
    check("arst_no_done",  64'(done_cyc_q.size() - dbase), 64'd0);
    check("arst_row_idx",  64'(row_idx), 64'd0);
    base = we_addr_q.size();
    pulse_start();
    send_row(1, 0, 96, 0);
    tick(3);
    check("arst_restart_count", 64'(we_addr_q.size() - base), 64'd1);
    check_rows("arst_restart", base, 1, 1);
    pulse_abort();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
